// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types and constants for the SD-card SPI arbiter slice.
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} own_state_e;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;
  localparam int SCK_DIV_DEFAULT = 1;
endpackage

// File: rtl/sd_spi_shifter.sv
// sd_spi_shifter: SPI mode-0 byte engine, MSB first, SCK half-period of SCK_DIV clk cycles.
module sd_spi_shifter #(
  parameter int SCK_DIV = sd_spi_pkg::SCK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txd,
  output logic [7:0] rxd,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);
  logic [7:0] div_cnt;
  logic [7:0] tx_sr;
  logic [3:0] half;
  logic       half_end;
  assign half_end = busy && div_cnt == 8'(SCK_DIV - 1);
  assign done     = half_end && half == 4'd15;
  assign sck      = busy & half[0];
  assign mosi     = busy ? tx_sr[7] : 1'b1;
  // Even halves end on a rising SCK edge (sample), odd halves on a falling edge (shift).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      half    <= '0;
      tx_sr   <= '0;
      rxd     <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      half    <= '0;
      tx_sr   <= txd;
    end else if (half_end) begin
      div_cnt <= '0;
      half    <= half + 4'd1;
      if (half[0]) tx_sr <= {tx_sr[6:0], 1'b0};
      else rxd <= {rxd[6:0], miso};
      if (done) busy <= 1'b0;
    end else if (busy) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: two-requester SD SPI bus arbiter with shared byte engine.
// Optional ownership watchdog enabled by defining SD_SPI_ARB_WDOG_EN.
module sd_spi_arbiter
  import sd_spi_pkg::*;
#(
  parameter int SCK_DIV   = SCK_DIV_DEFAULT,
  parameter int WDOG_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_cs_n,
  input  logic       req0_start,
  input  logic [7:0] req0_txd,
  output logic [7:0] req0_rxd,
  output logic       req0_grant,
  output logic       req0_busy,
  output logic       req0_revoked,
  input  logic       req1_cs_n,
  input  logic       req1_start,
  input  logic [7:0] req1_txd,
  output logic [7:0] req1_rxd,
  output logic       req1_grant,
  output logic       req1_busy,
  output logic       req1_revoked,
  output logic       sd_cs_n,
  output logic       sd_sck,
  output logic       sd_mosi,
  input  logic       sd_miso
);
  own_state_e state, state_nx;
  logic       last, last_nx;
  logic       own0, own1, acc, c0, c1, blk0, blk1, revoke;
  logic       sh_busy, sh_done, xfer_next;
  logic [7:0] sh_rxd;
  assign own0       = state == OWN0;
  assign own1       = state == OWN1;
  assign acc        = !sh_busy && (own0 && req0_start || own1 && req1_start);
  assign xfer_next  = acc || (sh_busy && !sh_done);
  assign c0         = !req0_cs_n && !blk0;
  assign c1         = !req1_cs_n && !blk1;
  assign req0_grant = own0;
  assign req1_grant = own1;
  assign req0_busy  = own0 && sh_busy;
  assign req1_busy  = own1 && sh_busy;
  assign sd_cs_n    = !(own0 || own1);
  sd_spi_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(acc),
    .txd  (own1 ? req1_txd : req0_txd),
    .rxd  (sh_rxd),
    .busy (sh_busy),
    .done (sh_done),
    .sck  (sd_sck),
    .mosi (sd_mosi),
    .miso (sd_miso)
  );
  always_comb begin
    state_nx = state;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (c0 && (!c1 || last == REQ_LDR)) begin
          state_nx = OWN0;
          last_nx  = REQ_CPU;
        end else if (c1) begin
          state_nx = OWN1;
          last_nx  = REQ_LDR;
        end
      end
      OWN0:    state_nx = (revoke || !(!req0_cs_n || xfer_next)) ? GAP : OWN0;
      OWN1:    state_nx = (revoke || !(!req1_cs_n || xfer_next)) ? GAP : OWN1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= REQ_LDR;
      req0_rxd <= '0;
      req1_rxd <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      if (sh_done && own0) req0_rxd <= sh_rxd;
      if (sh_done && own1) req1_rxd <= sh_rxd;
    end
  end
`ifdef SD_SPI_ARB_WDOG_EN
  logic [WDOG_BITS-1:0] wd_cnt;
  logic                 wd_cond;
  assign wd_cond      = !sh_busy && !acc && (own0 && !req1_cs_n || own1 && !req0_cs_n);
  assign revoke       = wd_cond && &wd_cnt;
  assign req0_revoked = revoke && own0;
  assign req1_revoked = revoke && own1;
  // A revoked requester stays blocked until it lets go of its cs_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      blk0   <= 1'b0;
      blk1   <= 1'b0;
    end else begin
      wd_cnt <= (acc || state_nx != state) ? '0 : wd_cond ? wd_cnt + 1'b1 : wd_cnt;
      blk0   <= req0_revoked || (blk0 && !req0_cs_n);
      blk1   <= req1_revoked || (blk1 && !req1_cs_n);
    end
  end
`else
  assign revoke       = 1'b0;
  assign blk0         = 1'b0;
  assign blk1         = 1'b0;
  assign req0_revoked = 1'b0;
  assign req1_revoked = 1'b0;
`endif
endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb_sd_spi_arbiter: directed scoreboard bench; DUT a uses SCK_DIV=1, DUT b uses SCK_DIV=2.
module tb_sd_spi_arbiter;
  logic clk = 1'b0;
  logic rst_n, req0_cs_n, req0_start, req1_cs_n, req1_start;
  logic [7:0] req0_txd, req1_txd;
  logic [7:0] req0_rxd, req1_rxd, req0_rxd_b, req1_rxd_b;
  logic req0_grant, req0_busy, req0_revoked, req1_grant, req1_busy, req1_revoked;
  logic req0_grant_b, req0_busy_b, req0_revoked_b, req1_grant_b, req1_busy_b, req1_revoked_b;
  logic sd_cs_n, sd_sck, sd_mosi, sd_cs_n_b, sd_sck_b, sd_mosi_b;
  int checks = 0;
  int errors = 0;
  typedef struct {logic id; logic [7:0] rxd; logic [7:0] mosi; int len;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sd_spi_arbiter #(.SCK_DIV(1), .WDOG_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_cs_n(req0_cs_n), .req0_start(req0_start), .req0_txd(req0_txd), .req0_rxd(req0_rxd),
    .req0_grant(req0_grant), .req0_busy(req0_busy), .req0_revoked(req0_revoked),
    .req1_cs_n(req1_cs_n), .req1_start(req1_start), .req1_txd(req1_txd), .req1_rxd(req1_rxd),
    .req1_grant(req1_grant), .req1_busy(req1_busy), .req1_revoked(req1_revoked),
    .sd_cs_n(sd_cs_n), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_mosi)
  );

  sd_spi_arbiter #(.SCK_DIV(2), .WDOG_BITS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_cs_n(req0_cs_n), .req0_start(req0_start), .req0_txd(req0_txd), .req0_rxd(req0_rxd_b),
    .req0_grant(req0_grant_b), .req0_busy(req0_busy_b), .req0_revoked(req0_revoked_b),
    .req1_cs_n(req1_cs_n), .req1_start(req1_start), .req1_txd(req1_txd), .req1_rxd(req1_rxd_b),
    .req1_grant(req1_grant_b), .req1_busy(req1_busy_b), .req1_revoked(req1_revoked_b),
    .sd_cs_n(sd_cs_n_b), .sd_sck(sd_sck_b), .sd_mosi(sd_mosi_b), .sd_miso(sd_mosi_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((req0_busy || req1_busy) && n < maxc) begin
      step(1);
      n++;
    end
    if (req0_busy || req1_busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic xfer0(input logic [7:0] d);
    sb.push_back('{id: 1'b0, rxd: d, mosi: d, len: 16});
    req0_txd = d;
    req0_start = 1'b1;
    step(1);
    req0_start = 1'b0;
  endtask

  // Monitor: measures each completed transfer of DUT a and retires it against the scoreboard.
  initial begin
    logic pbusy, psck, pid, cur;
    logic [7:0] mo;
    int len;
    exp_t e;
    pbusy = 1'b0; psck = 1'b0; pid = 1'b0; mo = '0; len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pbusy = 1'b0;
        psck = 1'b0;
      end else begin
        cur = req0_busy | req1_busy;
        if (cur && !pbusy) begin
          len = 0;
          mo = '0;
          pid = req1_busy;
        end
        if (cur) len++;
        if (sd_sck && !psck) mo = {mo[6:0], sd_mosi};
        if (!cur && pbusy) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_xfer", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("sb_id", 32'(pid), 32'(e.id));
            chk("sb_busy_len", len, e.len);
            chk("sb_mosi", 32'(mo), 32'(e.mosi));
            chk("sb_rxd", 32'(pid ? req1_rxd : req0_rxd), 32'(e.rxd));
          end
        end
        pbusy = cur;
        psck = sd_sck;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, first;
    logic csbad;
    rst_n = 1'b0; req0_cs_n = 1'b1; req1_cs_n = 1'b1;
    req0_start = 1'b0; req1_start = 1'b0; req0_txd = '0; req1_txd = '0;
    step(2);
    chk("rst_cs_n", sd_cs_n, 1);
    chk("rst_sck", sd_sck, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_grants", {req0_grant, req1_grant}, 0);
    chk("rst_busy", {req0_busy, req1_busy}, 0);
    chk("rst_revoked", {req0_revoked, req1_revoked}, 0);
    chk("rst_rxd", {req0_rxd, req1_rxd}, 0);
    rst_n = 1'b1;
    step(1);
    // Simultaneous requests: requester 0 first, then requester 1 after the gap.
    req0_cs_n = 1'b0; req1_cs_n = 1'b0;
    step(1);
    chk("rr_first_grant", {req0_grant, req1_grant, sd_cs_n}, 3'b100);
    req0_cs_n = 1'b1; req1_cs_n = 1'b1;
    step(1);
    chk("rr_gap", {req0_grant, req1_grant, sd_cs_n}, 3'b001);
    req0_cs_n = 1'b0; req1_cs_n = 1'b0;
    step(1);
    chk("rr_idle", {req0_grant, req1_grant, sd_cs_n}, 3'b001);
    step(1);
    chk("rr_second_grant", {req0_grant, req1_grant, sd_cs_n}, 3'b010);
    req0_cs_n = 1'b1; req1_cs_n = 1'b1;
    step(4);
    // Basic byte transfers, plus a start during busy that must be ignored.
    req0_cs_n = 1'b0;
    step(1);
    xfer0(8'hA5);
    chk("busy_on", req0_busy, 1);
    wait_idle(40);
    chk("rxd_a5", req0_rxd, 8'hA5);
    xfer0(8'h3C);
    step(5);
    req0_txd = 8'hFF; req0_start = 1'b1;
    step(1);
    req0_start = 1'b0;
    wait_idle(40);
    chk("rxd_3c", req0_rxd, 8'h3C);
    req0_cs_n = 1'b1;
    step(40);
    // Non-owner start is ignored.
    req0_cs_n = 1'b0;
    step(2);
    req1_txd = 8'h5A; req1_start = 1'b1;
    step(1);
    req1_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nonowner_sck", sd_sck, 0);
      chk("nonowner_busy", {req0_busy, req1_busy, req1_grant}, 0);
      step(1);
    end
    chk("nonowner_rxd", req1_rxd, 8'h00);
    req0_cs_n = 1'b1;
    step(4);
    // Release mid-transfer on the SCK_DIV=2 instance.
    req0_cs_n = 1'b0;
    step(1);
    xfer0(8'hC3);
    n = 0;
    csbad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!req0_busy_b) break;
      n++;
      if (sd_cs_n_b) csbad = 1'b1;
      if (i == 12) req0_cs_n = 1'b1;
      step(1);
    end
    chk("div2_busy_len", n, 32);
    chk("div2_cs_held", csbad, 0);
    chk("div2_gap", {sd_cs_n_b, req0_grant_b}, 2'b10);
    chk("div2_rxd", req0_rxd_b, 8'hC3);
    step(1);
    chk("div2_after_gap", {sd_cs_n_b, req0_grant_b}, 2'b10);
    step(30);
    // Reset in the middle of a transfer.
    req0_cs_n = 1'b0;
    step(1);
    req0_txd = 8'h0F; req0_start = 1'b1;
    step(1);
    req0_start = 1'b0;
    step(5);
    chk("mid_busy", req0_busy, 1);
    rst_n = 1'b0;
    step(1);
    chk("abort_pins", {sd_cs_n, sd_sck, sd_mosi}, 3'b101);
    chk("abort_busy", {req0_busy, req0_grant}, 0);
    chk("abort_rxd", req0_rxd, 8'h00);
    rst_n = 1'b1;
    req0_cs_n = 1'b1;
    step(3);
`ifdef SD_SPI_ARB_WDOG_EN
    req0_cs_n = 1'b0;
    step(1);
    req1_cs_n = 1'b0;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (req0_revoked) begin
        first = i;
        break;
      end
    end
    chk("wdog_revoke_at", first, 15);
    step(1);
    chk("wdog_gap", {req0_revoked, req0_grant, sd_cs_n}, 3'b001);
    step(1);
    chk("wdog_idle", req1_grant, 0);
    step(1);
    chk("wdog_grant1", {req0_grant, req1_grant}, 2'b01);
    req1_cs_n = 1'b1;
    step(3);
    chk("wdog_blocked", req0_grant, 0);
    req0_cs_n = 1'b1;
    step(1);
    req0_cs_n = 1'b0;
    step(1);
    chk("wdog_regrant", req0_grant, 1);
    req0_cs_n = 1'b1;
    step(3);
`else
    first = 0;
    req0_cs_n = 1'b0;
    step(1);
    req1_cs_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (req0_revoked || !req0_grant) first++;
    end
    chk("no_wdog_forced", first, 0);
    req0_cs_n = 1'b1; req1_cs_n = 1'b1;
    step(6);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
